// File: rtl/fetch_ctrl.sv
// fetch_ctrl: loads IMEM from a valid/ready stream, then sequences the fetch PC
// through RUN until a halt request, a bad redirect or running off the end of memory.
module fetch_ctrl #(
  parameter int          IMEM_SIZE = 256,
  parameter int          AW        = 8,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ld_valid,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_waddr,
  output logic [31:0]   imem_wdata,
  input  logic [31:0]   nextPC,
  input  logic          stall,
  input  logic          br_taken,
  input  logic [31:0]   br_target,
  input  logic          halt_req,
  output logic [31:0]   newPC,
  output logic          fetch_en,
  output logic          halted,
  output logic          fault,
  output logic [31:0]   fetch_cnt
);
  typedef enum logic [1:0] {LOAD, RUN, HALT} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q;
  logic          fault_q, fault_d;
  logic [31:0]   fetch_cnt_q, fetch_cnt_d;
  logic          accept, last_word, bad_br, off_end, go_halt, run, hold;
  logic [31:0]   pc_hold;
  // ld_ready is gated by RST so nothing is accepted while reset is held
  assign ld_ready   = ~RST & (state_q == LOAD);
  assign accept     = ld_valid & ld_ready;
  assign last_word  = ld_last | (cnt_q == AW'(IMEM_SIZE - 1));
  assign imem_we    = accept;
  assign imem_waddr = cnt_q;
  assign imem_wdata = ld_data;
  assign run        = state_q == RUN;
  assign pc_hold    = nextPC - 32'd4;
  assign bad_br     = br_taken & ((br_target[1:0] != 2'b00) | ((br_target >> 2) >= 32'(IMEM_SIZE)));
  assign off_end    = (nextPC >> 2) >= 32'(IMEM_SIZE);
  // a taken branch overrides both a stall and the off-the-end check
  assign go_halt    = halt_req | bad_br | (~br_taken & ~stall & off_end);
  assign hold       = (state_q == HALT) | go_halt | (stall & ~br_taken);
  assign newPC      = (state_q == LOAD) ? RESET_PC : hold ? pc_hold : br_taken ? br_target : nextPC;
  assign fetch_en   = run & ~stall;
  assign halted     = state_q == HALT;
  assign fault      = fault_q;
  assign fetch_cnt  = fetch_cnt_q;
  always_comb begin
    state_d     = (state_q == LOAD) ? ((accept & last_word) ? RUN : LOAD) :
                  (run & go_halt) ? HALT : state_q;
    fault_d     = fault_q | (run & bad_br & ~halt_req);
    fetch_cnt_d = (run & ~stall & ~go_halt) ? fetch_cnt_q + 32'd1 : fetch_cnt_q;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      fault_q     <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= accept ? cnt_q + AW'(1) : cnt_q;
      fault_q     <= fault_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed vectors for load, PC selection, halt/fault and reset behaviour.
module tb_fetch_ctrl;
  localparam int IMEM_SIZE = 256;
  localparam int AW = 8;
  logic          CLK, RST, ld_valid, ld_last, ld_ready, imem_we;
  logic [31:0]   ld_data, imem_wdata, nextPC, br_target, newPC, fetch_cnt;
  logic [AW-1:0] imem_waddr;
  logic          stall, br_taken, halt_req, fetch_en, halted, fault;
  int            n_pass = 0, n_tot = 0;

  fetch_ctrl #(.IMEM_SIZE(IMEM_SIZE), .AW(AW), .RESET_PC(32'h0)) dut (
    .CLK(CLK), .RST(RST), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .nextPC(nextPC), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .halt_req(halt_req), .newPC(newPC), .fetch_en(fetch_en), .halted(halted),
    .fault(fault), .fetch_cnt(fetch_cnt));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        stall, br, halt;
    logic [31:0] tgt, npc, e_pc;
    logic        e_fe, e_halted, e_fault;
    logic [31:0] e_cnt;
  } vec_t;
  vec_t v [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic set_run(input logic s, input logic b, input logic h, input logic [31:0] t, input logic [31:0] n);
    stall = s; br_taken = b; halt_req = h; br_target = t; nextPC = n;
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    RST = 1'b1; ld_valid = 1'b1; ld_last = 1'b0; ld_data = 32'hDEAD_BEEF;
    set_run(1'b0, 1'b1, 1'b1, 32'h4, 32'h8);
    #2;
    chk("rst_ld_ready", {31'b0, ld_ready}, 0);
    chk("rst_imem_we", {31'b0, imem_we}, 0);
    chk("rst_newpc", newPC, 0);
    chk("rst_fetch_en", {31'b0, fetch_en}, 0);
    chk("rst_halted", {31'b0, halted}, 0);
    chk("rst_fault", {31'b0, fault}, 0);
    chk("rst_fetch_cnt", fetch_cnt, 0);
    @(negedge CLK);
    RST = 1'b0; ld_valid = 1'b0;
    set_run(1'b0, 1'b0, 1'b0, 32'h0, 32'h4);
    tick();
  endtask

  task automatic load_word(input logic [31:0] d, input logic last, input logic [31:0] addr);
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    @(negedge CLK);
    chk("ld_ready", {31'b0, ld_ready}, 1);
    chk("ld_we", {31'b0, imem_we}, 1);
    chk("ld_waddr", {24'b0, imem_waddr}, addr);
    chk("ld_wdata", imem_wdata, d);
    chk("ld_newpc", newPC, 0);
    chk("ld_fetch_en", {31'b0, fetch_en}, 0);
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  initial begin
    v[0] = '{0, 0, 0, 32'h0,  32'h4,   32'h4,  1, 0, 0, 0};
    v[1] = '{0, 0, 0, 32'h0,  32'h8,   32'h8,  1, 0, 0, 1};
    v[2] = '{0, 0, 0, 32'h0,  32'hC,   32'hC,  1, 0, 0, 2};
    v[3] = '{1, 0, 0, 32'h0,  32'h10,  32'hC,  0, 0, 0, 3};
    v[4] = '{1, 0, 0, 32'h0,  32'h10,  32'hC,  0, 0, 0, 3};
    v[5] = '{1, 1, 0, 32'h40, 32'h10,  32'h40, 0, 0, 0, 3};
    v[6] = '{0, 0, 0, 32'h0,  32'h44,  32'h44, 1, 0, 0, 3};
    v[7] = '{0, 1, 0, 32'h42, 32'h48,  32'h44, 1, 0, 0, 4};
    v[8] = '{0, 1, 1, 32'h10, 32'h48,  32'h44, 0, 1, 1, 4};
    v[9] = '{0, 0, 0, 32'h0,  32'h100, 32'hFC, 0, 1, 1, 4};
    ld_data = 0; ld_last = 0; ld_valid = 0;
    do_reset();
    load_word(32'h2009_0001, 1'b0, 0);
    load_word(32'h2009_0002, 1'b0, 1);
    load_word(32'h2009_0003, 1'b1, 2);
    ld_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_run(v[i].stall, v[i].br, v[i].halt, v[i].tgt, v[i].npc);
      @(negedge CLK);
      chk($sformatf("v%0d_newpc", i), newPC, v[i].e_pc);
      chk($sformatf("v%0d_fetch_en", i), {31'b0, fetch_en}, {31'b0, v[i].e_fe});
      chk($sformatf("v%0d_halted", i), {31'b0, halted}, {31'b0, v[i].e_halted});
      chk($sformatf("v%0d_fault", i), {31'b0, fault}, {31'b0, v[i].e_fault});
      chk($sformatf("v%0d_fetch_cnt", i), fetch_cnt, v[i].e_cnt);
      chk($sformatf("v%0d_ld_ready", i), {31'b0, ld_ready}, 0);
      chk($sformatf("v%0d_imem_we", i), {31'b0, imem_we}, 0);
      tick();
    end
    do_reset();
    for (int i = 0; i < IMEM_SIZE; i++) begin
      ld_valid = 1'b1; ld_data = 32'h1000_0000 + i; ld_last = 1'b0;
      @(negedge CLK);
      chk("full_we", {31'b0, imem_we}, 1);
      chk("full_waddr", {24'b0, imem_waddr}, i);
      tick();
    end
    ld_data = 32'hBAD0_0000;
    set_run(1'b0, 1'b0, 1'b0, 32'h0, 32'h400);
    @(negedge CLK);
    chk("full_ld_ready", {31'b0, ld_ready}, 0);
    chk("full_extra_we", {31'b0, imem_we}, 0);
    chk("end_newpc", newPC, 32'h3FC);
    chk("end_fetch_en", {31'b0, fetch_en}, 1);
    tick();
    ld_valid = 1'b0;
    @(negedge CLK);
    chk("end_halted", {31'b0, halted}, 1);
    chk("end_fault", {31'b0, fault}, 0);
    chk("end_fetch_cnt", fetch_cnt, 0);
    chk("end_frozen_pc", newPC, 32'h3FC);
    do_reset();
    load_word(32'hAAAA_0000, 1'b0, 0);
    load_word(32'hAAAA_0001, 1'b0, 1);
    ld_valid = 1'b1;
    RST = 1'b1;
    #1;
    chk("mid_rst_ld_ready", {31'b0, ld_ready}, 0);
    chk("mid_rst_we", {31'b0, imem_we}, 0);
    @(negedge CLK);
    RST = 1'b0; ld_valid = 1'b0;
    tick();
    load_word(32'hCCCC_0001, 1'b1, 0);
    set_run(1'b0, 1'b1, 1'b0, 32'h400, 32'h8);
    @(negedge CLK);
    chk("rl_halted", {31'b0, halted}, 0);
    chk("rl_fault", {31'b0, fault}, 0);
    chk("rl_fetch_cnt", fetch_cnt, 0);
    chk("oor_newpc", newPC, 32'h4);
    tick();
    @(negedge CLK);
    chk("oor_halted", {31'b0, halted}, 1);
    chk("oor_fault", {31'b0, fault}, 1);
    do_reset();
    load_word(32'h1, 1'b1, 0);
    set_run(1'b1, 1'b0, 1'b1, 32'h0, 32'h8);
    @(negedge CLK);
    chk("hreq_newpc", newPC, 32'h4);
    tick();
    set_run(1'b0, 1'b0, 1'b0, 32'h0, 32'h8);
    @(negedge CLK);
    chk("hreq_halted", {31'b0, halted}, 1);
    chk("hreq_fault", {31'b0, fault}, 0);
    chk("hreq_fetch_cnt", fetch_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
